crc_encoder: RTL and testbench

Transmit-side codeword generator for the CRC-16 link. It accepts a 16-bit data word through a valid/ready handshake and computes its CRC-16 remainder bit-serially. It then presents the 32-bit codeword {data, crc} to downstream logic, where the codeword feeds the `ErrorCorrection` block's `erCW` input. An optional XOR mask, latched per word, lets benches inject known error patterns into the emitted codeword.

---
 rtl/crc_encoder.sv | 90 +++++++++
 tb/tb_crc_encoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/crc_encoder.sv
// CRC-16 codeword generator: accepts a 16-bit word, shifts its CRC out bit-serially
// (MSB first), then holds {data, crc} ^ mask until the downstream handshake completes.
module crc_encoder #(
  parameter logic [15:0] POLY = 16'h1021,
  parameter logic [15:0] INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dInValid,
  input  logic [15:0] dIn,
  input  logic [31:0] errMask,
  output logic        dInReady,
  output logic        cwValid,
  input  logic        cwReady,
  output logic [31:0] cw,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] data_q;
  logic [15:0] sh_q;
  logic [15:0] crc_q;
  logic [3:0]  cnt_q;
  logic [31:0] mask_q;
  logic [31:0] cw_q;

  logic        fb;
  logic [15:0] crc_next;

  assign fb       = crc_q[15] ^ sh_q[15];
  assign crc_next = {crc_q[14:0], 1'b0} ^ (fb ? POLY : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (dInValid) state_d = SHIFT;
      SHIFT:   if (cnt_q == 4'd15) state_d = HOLD;
      HOLD:    if (cwReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      sh_q   <= '0;
      crc_q  <= '0;
      cnt_q  <= '0;
      mask_q <= '0;
      cw_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (dInValid) begin
            data_q <= dIn;
            sh_q   <= dIn;
            mask_q <= errMask;
            crc_q  <= INIT;
            cnt_q  <= '0;
          end
        end
        SHIFT: begin
          crc_q <= crc_next;
          sh_q  <= {sh_q[14:0], 1'b0};
          cnt_q <= cnt_q + 4'd1;
          // Codeword captured from the post-16th-shift remainder, not the stale register.
          if (cnt_q == 4'd15) cw_q <= {data_q, crc_next} ^ mask_q;
        end
        default: ;
      endcase
    end
  end

  assign dInReady = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign cwValid  = (state_q == HOLD);
  assign cw       = cw_q;

endmodule

// File: tb/tb_crc_encoder.sv
// Self-checking bench for crc_encoder: directed vector table, handshake corner cases,
// asynchronous reset abort and randomized words against a polynomial-division model.
module tb_crc_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dInValid = 1'b0;
  logic [15:0] dIn = '0;
  logic [31:0] errMask = '0;
  logic        dInReady;
  logic        cwValid;
  logic        cwReady = 1'b0;
  logic [31:0] cw;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_q[$];
  logic [31:0] out_q[$];

  crc_encoder #(.POLY(16'h1021), .INIT(16'h0000)) dut (
    .clk(clk), .rst(rst), .dInValid(dInValid), .dIn(dIn), .errMask(errMask),
    .dInReady(dInReady), .cwValid(cwValid), .cwReady(cwReady), .cw(cw), .busy(busy)
  );

  always #5 clk = ~clk;

  // Observe handshakes with pre-edge values.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst && dInValid && dInReady) acc_q.push_back(cyc);
    if (rst && cwValid && cwReady) out_q.push_back(cw);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: long division of data*x^16 by x^16+x^12+x^5+1.
  function automatic logic [31:0] model(input logic [15:0] d, input logic [31:0] m);
    logic [31:0] r;
    r = {d, 16'h0000};
    for (int b = 31; b >= 16; b--)
      if (r[b]) r = r ^ (32'h0001_1021 << (b - 16));
    return {d, r[15:0]} ^ m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_word(input logic [15:0] d, input logic [31:0] m, input logic [31:0] exp,
                          input int ready_delay, input string nm);
    int lat;
    int n0;
    int o0;
    logic [31:0] held;
    n0 = acc_q.size();
    o0 = out_q.size();
    dInValid = 1'b1; dIn = d; errMask = m;
    lat = 0;
    while (acc_q.size() == n0 && lat < 40) begin @(posedge clk); #1; lat++; end
    dInValid = 1'b0; dIn = 16'($urandom); errMask = $urandom;
    chk({nm, "_accept"}, 32'(acc_q.size()), 32'(n0 + 1));
    lat = 0;
    while (!cwValid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk({nm, "_latency"}, 32'(lat), 32'd16);
    chk({nm, "_cw"}, cw, exp);
    held = cw;
    repeat (ready_delay) begin
      @(posedge clk); #1;
      chk({nm, "_hold"}, {cw[31:0]}, held);
    end
    cwReady = 1'b1;
    @(posedge clk); #1;
    cwReady = 1'b0;
    chk({nm, "_xfer_cnt"}, 32'(out_q.size()), 32'(o0 + 1));
    chk({nm, "_valid_drop"}, {31'd0, cwValid}, 32'd0);
    chk({nm, "_ready_back"}, {31'd0, dInReady}, 32'd1);
  endtask

  typedef struct {
    logic [15:0] d;
    logic [31:0] m;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int a0, a1, n0, o0, w;
    logic [31:0] held;
    logic [15:0] rd;
    logic [31:0] rm;

    vecs[0] = '{16'h0001, 32'h0000_0000, 32'h0001_1021};
    vecs[1] = '{16'h8000, 32'h0000_0000, 32'h8000_1B98};
    vecs[2] = '{16'h0003, 32'h0000_0000, 32'h0003_3063};
    vecs[3] = '{16'h0001, 32'h0000_0001, 32'h0001_1020};
    vecs[4] = '{16'h0000, 32'h0001_0000, 32'h0001_0000};

    // Reset state
    #12;
    chk("rst_ready", {31'd0, dInReady}, 32'd1);
    chk("rst_valid", {31'd0, cwValid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cw", cw, 32'h0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_word(vecs[i].d, vecs[i].m, vecs[i].exp, i, $sformatf("vec%0d", i));

    // Back-to-back with cwReady tied high
    cwReady = 1'b1;
    n0 = acc_q.size();
    o0 = out_q.size();
    dInValid = 1'b1; dIn = 16'h8000; errMask = '0;
    w = 0;
    while (acc_q.size() == n0 && w < 40) begin @(posedge clk); #1; w++; end
    dIn = 16'h0003;
    w = 0;
    while (acc_q.size() < n0 + 2 && w < 40) begin @(posedge clk); #1; w++; end
    dInValid = 1'b0;
    w = 0;
    while (out_q.size() < o0 + 2 && w < 40) begin @(posedge clk); #1; w++; end
    cwReady = 1'b0;
    chk("b2b_accepts", 32'(acc_q.size()), 32'(n0 + 2));
    chk("b2b_xfers", 32'(out_q.size()), 32'(o0 + 2));
    if (acc_q.size() >= n0 + 2 && out_q.size() >= o0 + 2) begin
      a0 = acc_q[n0]; a1 = acc_q[n0 + 1];
      chk("b2b_spacing", 32'(a1 - a0), 32'd18);
      chk("b2b_cw0", out_q[o0], 32'h8000_1B98);
      chk("b2b_cw1", out_q[o0 + 1], 32'h0003_3063);
    end

    // Long hold with upstream activity: no extra acceptance, cw stable
    n0 = acc_q.size();
    o0 = out_q.size();
    dInValid = 1'b1; dIn = 16'h1234; errMask = 32'h0;
    w = 0;
    while (!cwValid && w < 40) begin @(posedge clk); #1; w++; end
    chk("hold_cw", cw, model(16'h1234, 32'h0));
    held = cw;
    for (int k = 0; k < 10; k++) begin
      dInValid = 1'($urandom); dIn = 16'($urandom); errMask = $urandom;
      @(posedge clk); #1;
      chk("hold_stable", cw, held);
      chk("hold_notready", {31'd0, dInReady}, 32'd0);
    end
    dInValid = 1'b0;
    cwReady = 1'b1;
    @(posedge clk); #1;
    cwReady = 1'b0;
    chk("hold_accepts", 32'(acc_q.size()), 32'(n0 + 1));
    chk("hold_xfers", 32'(out_q.size()), 32'(o0 + 1));
    chk("hold_idle", {31'd0, dInReady}, 32'd1);

    // Asynchronous reset during shifting
    n0 = acc_q.size();
    dInValid = 1'b1; dIn = 16'hBEEF; errMask = 32'hFFFF_0000;
    w = 0;
    while (acc_q.size() == n0 && w < 40) begin @(posedge clk); #1; w++; end
    dInValid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_valid", {31'd0, cwValid}, 32'd0);
    chk("arst_cw", cw, 32'h0);
    chk("arst_ready", {31'd0, dInReady}, 32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    run_word(16'h0000, 32'h0, 32'h0000_0000, 0, "post_rst");

    // Randomized words
    for (int k = 0; k < 20; k++) begin
      rd = 16'($urandom);
      rm = ($urandom_range(0, 1) == 1) ? $urandom : 32'h0;
      run_word(rd, rm, model(rd, rm), $urandom_range(0, 3), $sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
